exec_pipe: RTL

Parametrised two-stage execute unit: ARM-style barrel shifter, 16-opcode data-processing ALU and an architectural NZCV flag register. It is the pipelined successor to the single-cycle datapath's shifter/ALU path. It has a valid/ready handshake on both sides and a synchronous flush. It sits between the register-read stage and the writeback/memory stage of the pipelined core.

---
 rtl/exec_pipe.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/exec_pipe.sv
// exec_pipe: two-stage execute unit. ARM-style barrel shifter and 16-opcode DP ALU
// with an architectural NZCV register, valid/ready on both sides and synchronous flush.
module exec_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [1:0]       shift_type,
   input  logic [7:0]       shift_amt,
   input  logic             shift_by_reg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             write_en,
   output logic [3:0]       flags
);
   localparam int L = $clog2(WIDTH);

   // Returns {carry_out, shifted_value}. The WIDTH+1-bit shifts put the carry-out
   // bit in the extra position, so out-of-range amounts fall out naturally.
   function automatic logic [WIDTH:0] barrel(
      input logic [WIDTH-1:0] a,
      input logic [1:0]       st,
      input logic [7:0]       n,
      input logic             by_reg,
      input logic             cin
   );
      logic [15:0]      amt;
      logic [15:0]      amt0;
      logic [15:0]      rot;
      logic [WIDTH:0]   t;
      logic [WIDTH-1:0] rv;
      logic [WIDTH:0]   res;
      amt  = by_reg ? {8'd0, n} : {{(16-L){1'b0}}, n[L-1:0]};
      amt0 = (amt == 16'd0 && !by_reg) ? 16'(WIDTH) : amt;
      rot  = {{(16-L){1'b0}}, n[L-1:0]};
      res  = {cin, a};
      case (st)
         2'd0: begin
            t   = {1'b0, a} << amt;
            res = (amt == 16'd0) ? {cin, a} : t;
         end
         2'd1: begin
            t   = {a, 1'b0} >> amt0;
            res = (amt0 == 16'd0) ? {cin, a} : {t[0], t[WIDTH:1]};
         end
         2'd2: begin
            t   = $signed({a, 1'b0}) >>> amt0;
            res = (amt0 == 16'd0) ? {cin, a} : {t[0], t[WIDTH:1]};
         end
         2'd3: begin
            if (by_reg && amt == 16'd0) begin
               res = {cin, a};
            end else if (rot == 16'd0) begin
               res = by_reg ? {a[WIDTH-1], a} : {a[0], cin, a[WIDTH-1:1]};
            end else begin
               rv  = (a >> rot) | (a << (16'(WIDTH) - rot));
               res = {rv[WIDTH-1], rv};
            end
         end
         default: res = {cin, a};
      endcase
      return res;
   endfunction

   logic             s1_valid_r;
   logic [3:0]       s1_op_r;
   logic             s1_set_flags_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;
   logic [1:0]       s1_shift_type_r;
   logic [7:0]       s1_shift_amt_r;
   logic             s1_by_reg_r;
   logic             s2_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             write_en_r;
   logic [3:0]       flags_r;

   logic             advance_s;
   logic             in_ready_s;
   logic             accept_s;
   logic [WIDTH:0]   sh_s;
   logic [WIDTH-1:0] shv_s;
   logic             shc_s;
   logic [WIDTH-1:0] logic_s;
   logic [WIDTH-1:0] add_x_s;
   logic [WIDTH-1:0] add_y_s;
   logic             add_c_s;
   logic             arith_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] res_s;
   logic             c_new_s;
   logic             v_new_s;
   logic [3:0]       nzcv_s;
   logic             we_s;

   assign advance_s  = s1_valid_r && (!s2_valid_r || out_ready) && !flush;
   assign in_ready_s = !reset && !flush && (!s1_valid_r || advance_s);
   assign accept_s   = in_valid && in_ready_s;

   assign in_ready  = in_ready_s;
   assign out_valid = s2_valid_r;
   assign result    = result_r;
   assign write_en  = write_en_r;
   assign flags     = flags_r;

   // Shift and ALU evaluation of the S1 op against the current architectural flags.
   always_comb begin
      sh_s    = barrel(s1_b_r, s1_shift_type_r, s1_shift_amt_r, s1_by_reg_r, flags_r[1]);
      shv_s   = sh_s[WIDTH-1:0];
      shc_s   = sh_s[WIDTH];
      logic_s = {WIDTH{1'b0}};
      add_x_s = s1_a_r;
      add_y_s = shv_s;
      add_c_s = 1'b0;
      arith_s = 1'b0;
      case (s1_op_r)
         4'h0, 4'h8: logic_s = s1_a_r & shv_s;
         4'h1, 4'h9: logic_s = s1_a_r ^ shv_s;
         4'hC:       logic_s = s1_a_r | shv_s;
         4'hD:       logic_s = shv_s;
         4'hE:       logic_s = s1_a_r & ~shv_s;
         4'hF:       logic_s = ~shv_s;
         4'h2, 4'hA: begin
            arith_s = 1'b1; add_y_s = ~shv_s; add_c_s = 1'b1;
         end
         4'h3: begin
            arith_s = 1'b1; add_x_s = shv_s; add_y_s = ~s1_a_r; add_c_s = 1'b1;
         end
         4'h4, 4'hB: arith_s = 1'b1;
         4'h5: begin
            arith_s = 1'b1; add_c_s = flags_r[1];
         end
         4'h6: begin
            arith_s = 1'b1; add_y_s = ~shv_s; add_c_s = flags_r[1];
         end
         4'h7: begin
            arith_s = 1'b1; add_x_s = shv_s; add_y_s = ~s1_a_r; add_c_s = flags_r[1];
         end
         default: logic_s = shv_s;
      endcase
      sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_c_s};
      if (arith_s) begin
         res_s   = sum_s[WIDTH-1:0];
         c_new_s = sum_s[WIDTH];
         v_new_s = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) && (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
      end else begin
         res_s   = logic_s;
         c_new_s = shc_s;
         v_new_s = flags_r[0];
      end
      nzcv_s = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_new_s, v_new_s};
      we_s   = (s1_op_r[3:2] != 2'b10);
   end

   // S1 capture: loads on accept, empties when its op advances or on flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_r      <= 1'b0;
         s1_op_r         <= 4'd0;
         s1_set_flags_r  <= 1'b0;
         s1_a_r          <= {WIDTH{1'b0}};
         s1_b_r          <= {WIDTH{1'b0}};
         s1_shift_type_r <= 2'd0;
         s1_shift_amt_r  <= 8'd0;
         s1_by_reg_r     <= 1'b0;
      end else if (flush) begin
         s1_valid_r <= 1'b0;
      end else if (accept_s) begin
         s1_valid_r      <= 1'b1;
         s1_op_r         <= op;
         s1_set_flags_r  <= set_flags;
         s1_a_r          <= src_a;
         s1_b_r          <= src_b;
         s1_shift_type_r <= shift_type;
         s1_shift_amt_r  <= shift_amt;
         s1_by_reg_r     <= shift_by_reg;
      end else if (advance_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // S2 output register: result and write_en hold while the consumer stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_r <= 1'b0;
         result_r   <= {WIDTH{1'b0}};
         write_en_r <= 1'b0;
      end else if (flush) begin
         s2_valid_r <= 1'b0;
      end else if (advance_s) begin
         s2_valid_r <= 1'b1;
         result_r   <= res_s;
         write_en_r <= we_s;
      end else if (out_ready) begin
         s2_valid_r <= 1'b0;
      end
   end

   // NZCV commits at advance in program order; a flush never rolls it back.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_r <= 4'b0000;
      end else if (advance_s && s1_set_flags_r) begin
         flags_r <= nzcv_s;
      end
   end
endmodule
